// File: rtl/issue_entry_fifo.sv
// First-word-fall-through queue decoupling decode from the issue/reorder path, with a one
// resident control-flow entry limit. Define ISSUE_FIFO_STATS_EN to enable the decode-stall counter.
module issue_entry_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         sbe_t = logic [63:0]
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  sbe_t                     decoded_entry_i,
   input  logic                     decoded_valid_i,
   input  logic                     is_ctrl_flow_i,
   output logic                     decoded_ack_o,
   output sbe_t                     issue_entry_o,
   output logic                     issue_valid_o,
   output logic                     is_ctrl_flow_o,
   input  logic                     issue_ack_i,
   output logic [$clog2(DEPTH):0]   usage_o,
   output logic [31:0]              stall_cnt_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   sbe_t             mem_q    [DEPTH];
   sbe_t             mem_d    [DEPTH];
   logic [DEPTH-1:0] cf_mem_q, cf_mem_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             cf_resident_q, cf_resident_d;

   logic empty, full, cf_block, accept, push, pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign cf_block = is_ctrl_flow_i & cf_resident_q;

   // Outputs are gated by reset so an asserted reset silences the fall-through path immediately.
   assign accept = rst_ni & decoded_valid_i & ~flush_i & ~cf_block & (~full | issue_ack_i);
   assign push   = accept & ~(empty & issue_ack_i);
   assign pop    = issue_ack_i & ~empty & ~flush_i;

   assign decoded_ack_o = accept;
   assign usage_o       = count_q;

   always_comb begin
      issue_entry_o  = decoded_entry_i;
      issue_valid_o  = 1'b0;
      is_ctrl_flow_o = is_ctrl_flow_i;
      if (empty) begin
         issue_valid_o = decoded_valid_i;
      end else begin
         issue_entry_o  = mem_q[rd_ptr_q];
         is_ctrl_flow_o = cf_mem_q[rd_ptr_q];
         issue_valid_o  = 1'b1;
      end
      if (flush_i || !rst_ni) begin
         issue_valid_o = 1'b0;
      end
   end

   // When full, a simultaneous pop frees rd_ptr's slot, which is also wr_ptr; the read happens first.
   always_comb begin
      mem_d    = mem_q;
      cf_mem_d = cf_mem_q;
      if (push) begin
         mem_d[wr_ptr_q]    = decoded_entry_i;
         cf_mem_d[wr_ptr_q] = is_ctrl_flow_i;
      end
   end

   always_comb begin
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      cf_resident_d = cf_resident_q;
      if (flush_i) begin
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
         count_d       = '0;
         cf_resident_d = 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (cf_mem_q[rd_ptr_q]) begin
               cf_resident_d = 1'b0;
            end
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (is_ctrl_flow_i) begin
               cf_resident_d = 1'b1;
            end
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         cf_resident_q <= 1'b0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         cf_resident_q <= cf_resident_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q    <= mem_d;
      cf_mem_q <= cf_mem_d;
   end

`ifdef ISSUE_FIFO_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (decoded_valid_i && !decoded_ack_o && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_issue_entry_fifo.sv
// Scoreboard bench for issue_entry_fifo: a queue model of stored entries predicts head, ack and usage.
// Expected stall count follows ISSUE_FIFO_STATS_EN.
module tb_issue_entry_fifo;

   typedef struct {
      logic [63:0] e;
      logic        cf;
   } ent_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic [63:0] decoded_entry_i = '0;
   logic        decoded_valid_i = 1'b0;
   logic        is_ctrl_flow_i = 1'b0;
   logic        decoded_ack_o;
   logic [63:0] issue_entry_o;
   logic        issue_valid_o;
   logic        is_ctrl_flow_o;
   logic        issue_ack_i = 1'b0;
   logic [2:0]  usage_o;
   logic [31:0] stall_cnt_o;

   int total = 0;
   int bad = 0;

   ent_t        stored[$];
   logic        m_cf;
   logic [31:0] m_stall;

   issue_entry_fifo #(.DEPTH(4)) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .flush_i(flush_i),
      .decoded_entry_i(decoded_entry_i),
      .decoded_valid_i(decoded_valid_i),
      .is_ctrl_flow_i(is_ctrl_flow_i),
      .decoded_ack_o(decoded_ack_o),
      .issue_entry_o(issue_entry_o),
      .issue_valid_o(issue_valid_o),
      .is_ctrl_flow_o(is_ctrl_flow_o),
      .issue_ack_i(issue_ack_i),
      .usage_o(usage_o),
      .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      stored.delete();
      m_cf    = 1'b0;
      m_stall = '0;
   endtask

   // One cycle: drive at negedge, check combinational outputs, update the model, then cross posedge.
   task automatic applyStimulus(input logic v, input logic [63:0] e, input logic cf,
                                input logic ack, input logic fl, input string tag);
      logic m_empty, exp_valid, exp_ack, m_push, m_pop;
      ent_t head;
      @(negedge clk_i);
      decoded_valid_i = v;
      decoded_entry_i = e;
      is_ctrl_flow_i  = cf;
      issue_ack_i     = ack;
      flush_i         = fl;
      #1;
      m_empty   = (stored.size() == 0);
      exp_valid = !fl && (m_empty ? v : 1'b1);
      exp_ack   = v && !fl && !(cf && m_cf) && ((stored.size() < 4) || ack);
      if (m_empty) begin
         head.e  = e;
         head.cf = cf;
      end else begin
         head = stored[0];
      end
      checkOutput({tag, ".valid"}, 64'(issue_valid_o), 64'(exp_valid));
      checkOutput({tag, ".ack"}, 64'(decoded_ack_o), 64'(exp_ack));
      checkOutput({tag, ".usage"}, 64'(usage_o), 64'(stored.size()));
      if (exp_valid) begin
         checkOutput({tag, ".entry"}, issue_entry_o, head.e);
         checkOutput({tag, ".cf"}, 64'(is_ctrl_flow_o), 64'(head.cf));
      end
      if (v && !exp_ack && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (fl) begin
         stored.delete();
         m_cf = 1'b0;
      end else begin
         m_push = exp_ack && !(m_empty && ack);
         m_pop  = ack && !m_empty;
         if (m_pop) begin
            if (stored[0].cf) m_cf = 1'b0;
            void'(stored.pop_front());
         end
         if (m_push) begin
            head.e  = e;
            head.cf = cf;
            stored.push_back(head);
            if (cf) m_cf = 1'b1;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk_i);
      rst_ni          = 1'b0;
      decoded_valid_i = 1'b0;
      issue_ack_i     = 1'b0;
      flush_i         = 1'b0;
      modelReset();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   function automatic logic [32:0] expStall();
`ifdef ISSUE_FIFO_STATS_EN
      return {1'b0, m_stall};
`else
      return 33'h0;
`endif
   endfunction

   initial begin
      modelReset();
      #2;
      checkOutput("rst.valid", 64'(issue_valid_o), 64'h0);
      checkOutput("rst.ack", 64'(decoded_ack_o), 64'h0);
      checkOutput("rst.usage", 64'(usage_o), 64'h0);
      checkOutput("rst.stall", 64'(stall_cnt_o), 64'h0);
      doReset();

      $display("[TB] fall-through");
      applyStimulus(1, 64'h1111_0000_0000_00A1, 0, 1, 0, "ft");

      $display("[TB] fill and drain");
      applyStimulus(1, 64'hA, 0, 0, 0, "fillA");
      applyStimulus(1, 64'hB, 0, 0, 0, "fillB");
      applyStimulus(1, 64'hC, 0, 0, 0, "fillC");
      applyStimulus(1, 64'hD, 0, 0, 0, "fillD");
      applyStimulus(1, 64'hE, 0, 0, 0, "fullE");
      checkOutput("full.usage", 64'(usage_o), 64'd4);
      for (int i = 0; i < 4; i++) applyStimulus(0, 64'h0, 0, 1, 0, "drain");
      checkOutput("drained.usage", 64'(usage_o), 64'd0);

      $display("[TB] full with simultaneous pop and push");
      applyStimulus(1, 64'hA, 0, 0, 0, "f2A");
      applyStimulus(1, 64'hB, 0, 0, 0, "f2B");
      applyStimulus(1, 64'hC, 0, 0, 0, "f2C");
      applyStimulus(1, 64'hD, 0, 0, 0, "f2D");
      applyStimulus(1, 64'hE, 0, 1, 0, "pushpop");
      checkOutput("pushpop.usage", 64'(usage_o), 64'd4);
      for (int i = 0; i < 4; i++) applyStimulus(0, 64'h0, 0, 1, 0, "drainBE");

      $display("[TB] control-flow limit");
      applyStimulus(1, 64'hB1, 1, 0, 0, "br1");
      applyStimulus(1, 64'hB2, 1, 0, 0, "br2blk");
      applyStimulus(1, 64'hB2, 1, 0, 0, "br2blk");
      applyStimulus(1, 64'hB2, 1, 1, 0, "br1pop");
      applyStimulus(1, 64'hB2, 1, 1, 0, "br2acc");

      $display("[TB] flush");
      applyStimulus(1, 64'h51, 0, 0, 0, "fl1");
      applyStimulus(1, 64'h52, 1, 0, 0, "fl2");
      applyStimulus(1, 64'h53, 0, 0, 0, "fl3");
      applyStimulus(1, 64'h54, 0, 1, 1, "flush");
      checkOutput("flush.usage", 64'(usage_o), 64'd0);
      applyStimulus(1, 64'h61, 1, 0, 0, "postfl");
      applyStimulus(1, 64'h62, 0, 0, 1, "flush2");

      $display("[TB] random traffic");
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), {$urandom(), $urandom()},
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 19) == 0), "rnd");
      end
      checkOutput("rnd.stall", 64'(stall_cnt_o), 64'(expStall()));

      $display("[TB] stall counter");
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(1, 64'(i + 'h70), 0, 0, 0, "sfill");
      for (int i = 0; i < 10; i++) applyStimulus(1, 64'h7F, 0, 0, 0, "shold");
`ifdef ISSUE_FIFO_STATS_EN
      checkOutput("stall10", 64'(stall_cnt_o), 64'd10);
`else
      checkOutput("stall10", 64'(stall_cnt_o), 64'd0);
`endif

      $display("[TB] async reset mid-fill");
      @(negedge clk_i);
      decoded_valid_i = 1'b1;
      issue_ack_i     = 1'b1;
      flush_i         = 1'b0;
      #1;
      rst_ni = 1'b0;
      #1;
      checkOutput("arst.valid", 64'(issue_valid_o), 64'h0);
      checkOutput("arst.ack", 64'(decoded_ack_o), 64'h0);
      checkOutput("arst.usage", 64'(usage_o), 64'h0);
      checkOutput("arst.stall", 64'(stall_cnt_o), 64'h0);
      modelReset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      applyStimulus(1, 64'h99, 0, 1, 0, "postrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
